// File: rtl/pm1_gcd_stage.sv
// Pollard p-1 gcd stage: captures a^M from the exponentiator and computes
// g = gcd(a^M - 1, N) with a binary (Stein) GCD, one step per cycle.
module pm1_gcd_stage #(
    parameter int unsigned W   = 100,
    parameter int unsigned N_W = 32,
    parameter int unsigned K_W = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   pow_result,
    input  logic           pow_done,
    input  logic [N_W-1:0] n,
    output logic           pow_ack,
    output logic           busy,
    output logic [W-1:0]   gcd_out,
    output logic           factor_found,
    output logic           gcd_valid,
    input  logic           gcd_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_STRIP = 3'd2,
        S_ODDA  = 3'd3,
        S_LOOP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   n_q;
    logic [K_W-1:0] k_q;

    logic [W-1:0]   a_nxt;
    logic [W-1:0]   b_nxt;
    logic [W-1:0]   n_nxt;
    logic [K_W-1:0] k_nxt;

    logic           pow_ack_nxt;
    logic           busy_nxt;
    logic [W-1:0]   gcd_out_nxt;
    logic           factor_found_nxt;
    logic           gcd_valid_nxt;

    logic           load_g;
    logic [W-1:0]   g_sel;

    logic           a_zero;
    logic           b_zero;
    logic           a_gt_b;
    logic [W-1:0]   diff_ab;
    logic [W-1:0]   diff_ba;
    logic [W-1:0]   g_shift;

    // Shared datapath terms for the LOAD / LOOP decisions
    assign a_zero  = (a_q == '0);
    assign b_zero  = (b_q == '0);
    assign a_gt_b  = (a_q > b_q);
    assign diff_ab = a_q - b_q;
    assign diff_ba = b_q - a_q;
    assign g_shift = a_q << k_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (pow_done) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (a_zero || b_zero) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_STRIP;
                end
            end
            S_STRIP: begin
                if (a_q[0] || b_q[0]) begin
                    state_nxt = S_ODDA;
                end
            end
            S_ODDA: begin
                if (a_q[0]) begin
                    state_nxt = S_LOOP;
                end
            end
            S_LOOP: begin
                if (b_zero) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (gcd_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output next values; outputs hold unless a state acts on them
    always_comb begin
        a_nxt            = a_q;
        b_nxt            = b_q;
        n_nxt            = n_q;
        k_nxt            = k_q;
        pow_ack_nxt      = 1'b0;
        busy_nxt         = busy;
        gcd_out_nxt      = gcd_out;
        factor_found_nxt = factor_found;
        gcd_valid_nxt    = gcd_valid;
        load_g           = 1'b0;
        g_sel            = '0;

        unique case (state)
            S_IDLE: begin
                if (pow_done) begin
                    a_nxt       = pow_result - W'(1);
                    b_nxt       = W'(n);
                    n_nxt       = W'(n);
                    k_nxt       = '0;
                    pow_ack_nxt = 1'b1;
                    busy_nxt    = 1'b1;
                end
            end
            S_LOAD: begin
                // a==0 && b==0 falls into the first branch and yields g=0
                if (a_zero) begin
                    load_g = 1'b1;
                    g_sel  = b_q;
                end else if (b_zero) begin
                    load_g = 1'b1;
                    g_sel  = a_q;
                end
            end
            S_STRIP: begin
                if (!a_q[0] && !b_q[0]) begin
                    a_nxt = a_q >> 1;
                    b_nxt = b_q >> 1;
                    k_nxt = k_q + K_W'(1);
                end
            end
            S_ODDA: begin
                if (!a_q[0]) begin
                    a_nxt = a_q >> 1;
                end
            end
            S_LOOP: begin
                // a stays odd; the smaller value always lands in a
                if (b_zero) begin
                    load_g = 1'b1;
                    g_sel  = g_shift;
                end else if (!b_q[0]) begin
                    b_nxt = b_q >> 1;
                end else if (a_gt_b) begin
                    a_nxt = b_q;
                    b_nxt = diff_ab;
                end else begin
                    b_nxt = diff_ba;
                end
            end
            S_DONE: begin
                if (gcd_ready) begin
                    gcd_valid_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                end
            end
            default: begin
                busy_nxt      = 1'b0;
                gcd_valid_nxt = 1'b0;
            end
        endcase

        if (load_g) begin
            gcd_out_nxt      = g_sel;
            factor_found_nxt = (g_sel != W'(1)) && (g_sel != n_q);
            gcd_valid_nxt    = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q          <= '0;
            b_q          <= '0;
            n_q          <= '0;
            k_q          <= '0;
            pow_ack      <= 1'b0;
            busy         <= 1'b0;
            gcd_out      <= '0;
            factor_found <= 1'b0;
            gcd_valid    <= 1'b0;
        end else begin
            a_q          <= a_nxt;
            b_q          <= b_nxt;
            n_q          <= n_nxt;
            k_q          <= k_nxt;
            pow_ack      <= pow_ack_nxt;
            busy         <= busy_nxt;
            gcd_out      <= gcd_out_nxt;
            factor_found <= factor_found_nxt;
            gcd_valid    <= gcd_valid_nxt;
        end
    end

endmodule
